// File: rtl/ifu_pkg.sv
// Shared constants and types for the instruction fetch unit.
// Queue entries carry the fetched word together with its PC+4 tag.
package ifu_pkg;

  localparam logic [31:0] INST_BUBBLE = 32'h0000_0000;
  localparam logic [31:0] INST_NOP    = 32'h0000_0013;
  localparam logic [31:0] PC_STEP     = 32'h0000_0004;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] pc_in);
    return {pc_in[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; a flush wins over any same-cycle push or pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == CNT_ZERO);
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues word requests, queues returned
// words with their PC+4 tags and hands them to decode; accepts redirects.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] addr
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW:0]   DEPTH_W  = (CW+1)'(DEPTH);

  logic [31:0]   pc_r;
  logic [CW-1:0] outst_r;
  logic [CW-1:0] drop_r;
  logic [CW-1:0] rsp_dec_s;
  logic [CW-1:0] q_count_s;
  logic [CW-1:0] tag_count_s;
  logic [CW:0]   inflight_s;
  logic          req_valid_s;
  logic          req_fire_s;
  logic          rsp_keep_s;
  logic          pop_fire_s;
  logic          q_full_s;
  logic          q_empty_s;
  logic          tag_full_s;
  logic          tag_empty_s;
  logic [31:0]   tag_head_s;
  fetch_entry_t  q_push_s;
  fetch_entry_t  q_head_s;
  logic          unused_s;

  // Issue only while every in-flight response is guaranteed a queue slot.
  always_comb begin
    inflight_s = {1'b0, outst_r} + {1'b0, q_count_s};
    if (rst || redirect_valid) begin
      req_valid_s = 1'b0;
    end else begin
      req_valid_s = (inflight_s < DEPTH_W);
    end
  end

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = pc_r;
  assign req_fire_s     = req_valid_s && imem_req_ready;
  assign rsp_keep_s     = imem_rsp_valid && !redirect_valid && (drop_r == CNT_ZERO);
  assign rsp_dec_s      = imem_rsp_valid ? CNT_ONE : CNT_ZERO;
  assign pop_fire_s     = inst_valid && inst_ready;
  assign q_push_s       = '{inst: imem_rsp_data, addr: tag_head_s};

  // Present the queue head, or a zero bubble while the queue is empty.
  always_comb begin
    if (q_empty_s) begin
      inst_valid = 1'b0;
      inst       = INST_BUBBLE;
      addr       = 32'h0000_0000;
    end else begin
      inst_valid = 1'b1;
      inst       = q_head_s.inst;
      addr       = q_head_s.addr;
    end
  end

  // PC, outstanding-request and drop counters; a redirect turns every
  // request still in flight into one to be discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r    <= word_align(RESET_PC);
      outst_r <= CNT_ZERO;
      drop_r  <= CNT_ZERO;
    end else if (redirect_valid) begin
      pc_r    <= word_align(redirect_pc);
      outst_r <= outst_r - rsp_dec_s;
      drop_r  <= outst_r - rsp_dec_s;
    end else begin
      if (req_fire_s) begin
        pc_r <= pc_r + PC_STEP;
      end
      case ({req_fire_s, imem_rsp_valid})
        2'b10:   outst_r <= outst_r + CNT_ONE;
        2'b01:   outst_r <= outst_r - CNT_ONE;
        default: outst_r <= outst_r;
      endcase
      if (imem_rsp_valid && (drop_r != CNT_ZERO)) begin
        drop_r <= drop_r - CNT_ONE;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_inst_q (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_keep_s),
    .push_data (q_push_s),
    .pop       (pop_fire_s),
    .flush     (redirect_valid),
    .head      (q_head_s),
    .count     (q_count_s),
    .full      (q_full_s),
    .empty     (q_empty_s)
  );

  // Tags of requests still owed a kept response, oldest first.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire_s),
    .push_data (pc_r + PC_STEP),
    .pop       (rsp_keep_s),
    .flush     (redirect_valid),
    .head      (tag_head_s),
    .count     (tag_count_s),
    .full      (tag_full_s),
    .empty     (tag_empty_s)
  );

  assign unused_s = ^{tag_count_s, tag_full_s, tag_empty_s, q_full_s, redirect_pc[1:0]};

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: a cycle table after reset, then directed
// stall/redirect sequences, a randomized-latency stream and a PC-wrap instance.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst, addr;

  logic        w_req_valid;
  logic        w_req_ready = 1'b1;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data  = 32'h0;
  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc    = 32'h0;
  logic        w_inst_valid;
  logic        w_inst_ready = 1'b1;
  logic [31:0] w_inst, w_addr;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .addr(addr)
  );

  ifu_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_w (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .inst_valid(w_inst_valid), .inst_ready(w_inst_ready), .inst(w_inst), .addr(w_addr)
  );

  typedef struct { logic [31:0] a; int due; } req_t;
  typedef struct { logic [31:0] inst; logic [31:0] addr; } deliv_t;
  typedef struct {
    logic rst; logic req_ready; logic inst_ready;
    logic exp_rv; logic [31:0] exp_ra; logic exp_iv; logic [31:0] exp_inst; logic [31:0] exp_addr;
  } vec_t;

  req_t        pend[$];
  logic [31:0] w_acc[$];
  deliv_t      w_del[$];
  vec_t        tbl[10];

  int n_pass = 0, n_total = 0;
  int cyc = 0, n_accept = 0, n_deliv = 0;
  logic        cfg_rst = 1'b1, cfg_ready = 1'b1, cfg_inst_ready = 1'b1;
  logic        cfg_redir = 1'b0, cfg_rand = 1'b0, chk_en = 1'b0;
  logic [31:0] cfg_rpc = 32'h0, exp_next = 32'h4;
  int          cfg_lat = 1;
  logic        w_next_valid = 1'b0;
  logic [31:0] w_next_addr  = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // One clock cycle: drive inputs and memory responses, then sample outputs.
  task automatic step();
    req_t   r;
    deliv_t d;
    @(posedge clk);
    #1;
    cyc++;
    rst            = cfg_rst;
    imem_req_ready = cfg_ready;
    inst_ready     = cfg_inst_ready;
    redirect_valid = cfg_redir;
    redirect_pc    = cfg_rpc;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (cfg_rst) pend.delete();
    else if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pend[0].a;
      void'(pend.pop_front());
    end
    w_rsp_valid = w_next_valid && !cfg_rst;
    w_rsp_data  = w_next_addr;
    #1;
    if (imem_req_valid && imem_req_ready) begin
      r.a   = imem_req_addr;
      r.due = cyc + (cfg_rand ? int'($urandom_range(1, 3)) : cfg_lat);
      pend.push_back(r);
      n_accept++;
    end
    if (inst_valid && inst_ready) begin
      n_deliv++;
      if (chk_en) begin
        check("deliver_addr", addr, exp_next);
        check("deliver_inst", inst, exp_next - 32'd4);
        exp_next = exp_next + 32'd4;
      end
    end
    w_next_valid = w_req_valid;
    w_next_addr  = w_req_addr;
    if (w_req_valid) w_acc.push_back(w_req_addr);
    if (w_inst_valid) begin
      d.inst = w_inst;
      d.addr = w_addr;
      w_del.push_back(d);
    end
  endtask

  task automatic do_reset();
    cfg_rst = 1'b1; cfg_redir = 1'b0; cfg_rand = 1'b0; chk_en = 1'b0;
    cfg_ready = 1'b1; cfg_inst_ready = 1'b1; cfg_lat = 1;
    repeat (3) step();
    cfg_rst = 1'b0;
    w_acc.delete(); w_del.delete();
    n_accept = 0; n_deliv = 0;
  endtask

  initial begin
    //           rst   rdy   irdy  rv    req_addr      iv    inst          addr
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0000_0000, 32'h0000_0000};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000, 32'h0000_0004};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004, 32'h0000_0008};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_000C, 1'b0, 32'h0000_0000, 32'h0000_0000};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 1'b1, 32'h0000_0008, 32'h0000_000C};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C, 32'h0000_0010};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0014, 1'b0, 32'h0000_0000, 32'h0000_0000};
    tbl[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0018, 1'b1, 32'h0000_0010, 32'h0000_0014};

    // Reset and the first cycles of a 1-cycle-latency free-running stream.
    cfg_rst = 1'b1;
    repeat (2) step();
    for (int i = 0; i < 10; i++) begin
      cfg_rst = tbl[i].rst; cfg_ready = tbl[i].req_ready; cfg_inst_ready = tbl[i].inst_ready;
      step();
      check($sformatf("tbl%0d_req_valid", i), imem_req_valid, tbl[i].exp_rv);
      check($sformatf("tbl%0d_req_addr", i), imem_req_addr, tbl[i].exp_ra);
      check($sformatf("tbl%0d_inst_valid", i), inst_valid, tbl[i].exp_iv);
      check($sformatf("tbl%0d_inst", i), inst, tbl[i].exp_inst);
      check($sformatf("tbl%0d_addr", i), addr, tbl[i].exp_addr);
    end

    // Decode stalls for 10 cycles: only DEPTH requests go out, nothing lost.
    do_reset();
    cfg_inst_ready = 1'b0;
    repeat (10) step();
    check("stall_accepts", n_accept, 2);
    check("stall_req_valid", imem_req_valid, 1'b0);
    check("stall_inst_valid", inst_valid, 1'b1);
    check("stall_head_inst", inst, 32'h0);
    cfg_inst_ready = 1'b1; chk_en = 1'b1; exp_next = 32'h4; n_deliv = 0;
    repeat (12) step();
    check("stall_resume_deliv", n_deliv, 8);

    // Redirect with two requests outstanding: both stale responses dropped.
    do_reset();
    cfg_lat = 3;
    step(); step();
    check("redir_accepts", n_accept, 2);
    cfg_redir = 1'b1; cfg_rpc = 32'h0000_0103;
    step();
    check("redir_req_valid", imem_req_valid, 1'b0);
    cfg_redir = 1'b0; chk_en = 1'b1; exp_next = 32'h0000_0104;
    step();
    check("redir_next_addr", imem_req_addr, 32'h0000_0100);
    step();
    check("redir_issue_valid", imem_req_valid, 1'b1);
    check("redir_issue_addr", imem_req_addr, 32'h0000_0100);
    repeat (12) step();
    check("redir_delivered", n_deliv > 0, 1'b1);

    // Redirect coinciding with a response and a pop, then a back-to-back redirect.
    do_reset();
    chk_en = 1'b1; exp_next = 32'h4;
    step(); step();
    cfg_redir = 1'b1; cfg_rpc = 32'h0000_0200;
    step();
    check("coinc_rsp_seen", imem_rsp_valid, 1'b1);
    check("coinc_pop_deliv", n_deliv, 1);
    cfg_rpc = 32'h0000_0300;
    step();
    check("redir2_req_valid", imem_req_valid, 1'b0);
    cfg_redir = 1'b0; exp_next = 32'h0000_0304;
    step();
    check("redir2_issue_valid", imem_req_valid, 1'b1);
    check("redir2_issue_addr", imem_req_addr, 32'h0000_0300);
    check("redir2_c1_iv", inst_valid, 1'b0);
    step();
    check("redir2_c2_iv", inst_valid, 1'b0);
    step();
    check("redir2_c3_iv", inst_valid, 1'b1);
    check("redir2_c3_addr", addr, 32'h0000_0304);
    check("redir2_deliv_cnt", n_deliv, 2);

    // Random memory backpressure and 1-3 cycle latency over 1000 instructions.
    do_reset();
    cfg_rand = 1'b1; chk_en = 1'b1; exp_next = 32'h4;
    for (int k = 0; k < 20000 && n_deliv < 1000; k++) begin
      cfg_ready      = 1'($urandom_range(0, 1));
      cfg_inst_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    check("random_1000_reached", n_deliv >= 1000, 1'b1);

    // PC wrap on the instance reset to FFFF_FFF8.
    do_reset();
    repeat (8) step();
    if (w_acc.size() >= 3) begin
      check("wrap_req0", w_acc[0], 32'hFFFF_FFF8);
      check("wrap_req1", w_acc[1], 32'hFFFF_FFFC);
      check("wrap_req2", w_acc[2], 32'h0000_0000);
    end else check("wrap_req_count", w_acc.size(), 3);
    if (w_del.size() >= 2) begin
      check("wrap_del0_addr", w_del[0].addr, 32'hFFFF_FFFC);
      check("wrap_del1_inst", w_del[1].inst, 32'hFFFF_FFFC);
      check("wrap_del1_addr", w_del[1].addr, 32'h0000_0000);
    end else check("wrap_del_count", w_del.size(), 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
